// File: rtl/disparity_sched.sv
// rtl/disparity_sched.sv - frame scheduler feeding disparity_calc with credit-based result FIFO
// Issues raster-tagged cost vectors, checks returned tags, buffers results for downstream.
module disparity_sched #(
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int COST_W     = 864,
   parameter int CALC_LAT   = 19,
   parameter int FIFO_DEPTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              frame_done,
   input  logic              s_cost_valid,
   output logic              s_cost_ready,
   input  logic [COST_W-1:0] s_cost_data,
   output logic              calc_en,
   output logic [COST_W-1:0] calc_cost,
   output logic [9:0]        calc_row,
   output logic [9:0]        calc_col,
   input  logic              calc_valid,
   input  logic [31:0]       calc_disparity,
   input  logic [9:0]        calc_row_out,
   input  logic [9:0]        calc_col_out,
   output logic              m_disp_valid,
   input  logic              m_disp_ready,
   output logic [31:0]       m_disp_data,
   output logic [9:0]        m_disp_row,
   output logic [9:0]        m_disp_col,
   output logic              m_disp_last,
   output logic              seq_err,
   output logic              ovf_err
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int EW    = 32 + 10 + 10 + 1;
   localparam logic [9:0]       LAST_COL = 10'(IMG_W - 1);
   localparam logic [9:0]       LAST_ROW = 10'(IMG_H - 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

   if (FIFO_DEPTH < CALC_LAT + 2) begin : g_depth_chk
      $error("FIFO_DEPTH must cover CALC_LAT+2 results");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              r_state;
   logic                r_busy, r_frame_done, r_calc_en, r_seq_err, r_ovf_err;
   logic [COST_W-1:0]   r_calc_cost;
   logic [9:0]          r_calc_row, r_calc_col;
   logic [9:0]          r_irow, r_icol, r_erow, r_ecol;
   logic [CNT_W-1:0]    r_inflight, r_count;
   logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
   logic [EW-1:0]       r_mem [FIFO_DEPTH];

   logic                w_active, w_ret, w_ret_dec, w_full, w_empty, w_pop, w_push;
   logic                w_credit_ok, w_acc, w_issue_last, w_ret_last;
   logic [CNT_W:0]      w_used;
   logic [EW-1:0]       w_head;

   // Results arriving while idle are leftovers of an aborted frame and are discarded.
   assign w_active     = (r_state != S_IDLE);
   assign w_ret        = calc_valid & w_active;
   assign w_ret_dec    = w_ret & (r_inflight != '0);
   assign w_full       = (r_count == DEPTH_C);
   assign w_empty      = (r_count == '0);
   assign w_pop        = ~w_empty & m_disp_ready;
   assign w_push       = w_ret & (~w_full | w_pop);
   assign w_used       = {1'b0, r_count} + {1'b0, r_inflight};
   assign w_credit_ok  = (w_used < (CNT_W + 1)'(FIFO_DEPTH));
   assign s_cost_ready = (r_state == S_RUN) & w_credit_ok;
   assign w_acc        = s_cost_valid & s_cost_ready;
   assign w_issue_last = (r_irow == LAST_ROW) & (r_icol == LAST_COL);
   assign w_ret_last   = (calc_row_out == LAST_ROW) & (calc_col_out == LAST_COL);
   assign w_head       = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= {calc_disparity, calc_row_out, calc_col_out, w_ret_last};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_calc_en    <= 1'b0;
         r_calc_cost  <= '0;
         r_calc_row   <= '0;
         r_calc_col   <= '0;
         r_irow       <= '0;
         r_icol       <= '0;
         r_erow       <= '0;
         r_ecol       <= '0;
         r_inflight   <= '0;
         r_count      <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_seq_err    <= 1'b0;
         r_ovf_err    <= 1'b0;
      end else begin
         r_calc_en <= w_acc;
         if (w_acc) begin
            r_calc_cost <= s_cost_data;
            r_calc_row  <= r_irow;
            r_calc_col  <= r_icol;
            if (r_icol == LAST_COL) begin
               r_icol <= '0;
               r_irow <= r_irow + 10'd1;
            end else begin
               r_icol <= r_icol + 10'd1;
            end
         end

         case ({w_acc, w_ret_dec})
            2'b10:   r_inflight <= r_inflight + CNT_W'(1);
            2'b01:   r_inflight <= r_inflight - CNT_W'(1);
            default: r_inflight <= r_inflight;
         endcase

         if (w_ret) begin
            if ((calc_row_out != r_erow) || (calc_col_out != r_ecol))
               r_seq_err <= 1'b1;
            if (r_ecol == LAST_COL) begin
               r_ecol <= '0;
               r_erow <= r_erow + 10'd1;
            end else begin
               r_ecol <= r_ecol + 10'd1;
            end
         end
         if (w_ret & ~w_push)
            r_ovf_err <= 1'b1;

         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
                  r_irow  <= '0;
                  r_icol  <= '0;
                  r_erow  <= '0;
                  r_ecol  <= '0;
               end
            end
            S_RUN: begin
               if (w_acc & w_issue_last)
                  r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if ((r_inflight == '0) && w_empty) begin
                  r_state      <= S_DONE;
                  r_frame_done <= 1'b1;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_frame_done <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   assign busy         = r_busy;
   assign frame_done   = r_frame_done;
   assign calc_en      = r_calc_en;
   assign calc_cost    = r_calc_cost;
   assign calc_row     = r_calc_row;
   assign calc_col     = r_calc_col;
   assign seq_err      = r_seq_err;
   assign ovf_err      = r_ovf_err;
   // Head fields are masked while empty so stale RAM contents never reach the port.
   assign m_disp_valid = ~w_empty;
   assign m_disp_data  = w_empty ? 32'd0 : w_head[52:21];
   assign m_disp_row   = w_empty ? 10'd0 : w_head[20:11];
   assign m_disp_col   = w_empty ? 10'd0 : w_head[10:1];
   assign m_disp_last  = ~w_empty & w_head[0];

endmodule
